imem_bootloader: RTL and testbench
==================================

# imem_bootloader

Parametrised instruction memory for the single-cycle MIPS core. Program contents arrive at run time over a valid/ready load port instead of being hard-coded. After reset it zero-fills its storage, accepts a program image word by word, then serves combinational instruction fetches to the core. It sits between the core's PC/fetch path and a host or testbench loader, and flags illegal fetch addresses.

## Interface
- DATA_WIDTH, 32, instruction word width
- DEPTH, 256, number of words stored (power of two, ≥ 2)
- ADDR_LSB, 2, byte-offset bits dropped from Address (word-aligned fetch)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; forces CLEAR state
- Address  in  32  core fetch byte address
- Instruction  out  DATA_WIDTH  fetched word (combinational)
- addr_fault  out  1  fetch address misaligned or out of range (combinational)
- prog_valid  in  1  loader presents prog_data
- prog_data  in  DATA_WIDTH  program word
- prog_last  in  1  current word is the final word of the image
- prog_ready  out  1  block accepts a word this cycle
- reload  in  1  one-cycle pulse; restart clear/load from RUN
- ready  out  1  image loaded; core may fetch
- load_count  out  $clog2(DEPTH+1)  words accepted in current load

## Operation
- States: CLEAR, LOAD, RUN. Reset value: CLEAR, clear index 0, write pointer 0, load_count 0.
- Output values while reset is asserted: prog_ready 0, ready 0, Instruction 0, addr_fault 0.
- CLEAR: writes 0 (NOP) to word[clear index] each cycle and increments the index. The edge that writes word DEPTH-1 moves to LOAD.
- LOAD: prog_ready=1. On each cycle with prog_valid&prog_ready, prog_data is written to word[wptr], and wptr and load_count increment. If that word has prog_last=1 or wptr==DEPTH-1, the state moves to RUN on the same edge. Cycles without prog_valid write nothing.
- RUN: ready=1, prog_ready=0. prog_valid is ignored; storage is never written.
- Fetch index = Address[ADDR_LSB+$clog2(DEPTH)-1:ADDR_LSB].
- addr_fault=1 only in RUN, when Address[ADDR_LSB-1:0]≠0 or Address ≥ DEPTH<<ADDR_LSB.
- Instruction = word[index] only in RUN with addr_fault=0; otherwise 0.
- reload=1 in RUN moves to CLEAR with index, wptr and load_count set to 0. reload in CLEAR or LOAD is ignored. reset and reload together: reset wins (same result).
- Reset mid-CLEAR or mid-LOAD restarts from CLEAR index 0. Partially loaded words are zeroed by the new clear.
- Write and fetch to the same word cannot coincide, because writes happen only outside RUN.

## Timing
- After reset deasserts, prog_ready rises after exactly DEPTH cycles.
- Each accepted word takes one cycle; back-to-back acceptance is sustained at 1 word/cycle.
- ready rises on the cycle after the final handshake.
- Fetch latency is 0 cycles (combinational), compatible with the single-cycle datapath.
- prog_ready and ready are Moore outputs (state-decoded). No combinational path runs from prog_valid to prog_ready.

## Structure
- Shared package imem_pkg: state enum {CLEAR, LOAD, RUN} and constant NOP_WORD = 0.
- Sub-module imem_storage: DEPTH×DATA_WIDTH array with one synchronous write port and one asynchronous read port.
- imem_bootloader holds the FSM, counters, address checking and output muxing.

## Test plan
All scenarios use DEPTH=32.
- Reset then load 19 words (0x20040005, 0x00001026, 0x0C000004, …) with prog_last on word 18:
  - prog_ready high 32 cycles after reset release; ready high on the cycle after word 18.
  - Address 0x08 → 0x0C000004; Address 0x00 → 0x20040005; Address 0x50 → 0; load_count=19.
- Load 32 words without prog_last:
  - RUN is entered after word 31.
  - A further prog_valid is ignored; word[0] is unchanged.
- Address checks in RUN:
  - Address 0x06 → addr_fault=1, Instruction=0.
  - Address 0x80 → addr_fault=1.
  - Address 0x7C → addr_fault=0, returns word 31.
- prog_valid toggling every other cycle: only handshake cycles advance load_count; the words land at consecutive indices.
- Reset asserted after 5 accepted words:
  - ready stays 0 and load_count returns to 0.
  - After re-clear, word[2] reads 0 once RUN is reached with a 1-word image.
- reload pulse in RUN:
  - ready drops next cycle; prog_ready returns 32 cycles later.
  - Prior contents are zero; reload pulsed during LOAD has no effect.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types for the boot-loaded instruction memory: FSM states and the fill word.
// Pure declarations; no timing or flow control of its own.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

  // All-zero word decodes as sll $0,$0,0 on MIPS, i.e. a NOP.
  localparam int NOP_WORD = 0;

endpackage

// File: rtl/imem_storage.sv
// DEPTH x DATA_WIDTH word array: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read is combinational; no flow control.
module imem_storage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [AW-1:0]         wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]         rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/imem_bootloader.sv
// Instruction memory that zero-fills after reset, takes its image over a valid/ready port, then serves 0-cycle fetches.
// prog_ready is state-decoded (high only in LOAD); one word accepted per handshake cycle, no combinational valid->ready path.
module imem_bootloader
  import imem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_LSB   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [31:0]                  Address,
  output logic [DATA_WIDTH-1:0]        Instruction,
  output logic                         addr_fault,
  input  logic                         prog_valid,
  input  logic [DATA_WIDTH-1:0]        prog_data,
  input  logic                         prog_last,
  output logic                         prog_ready,
  input  logic                         reload,
  output logic                         ready,
  output logic [$clog2(DEPTH+1)-1:0]   load_count
);

  localparam int            AW       = $clog2(DEPTH);
  localparam int            CW       = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [31:0]   LSB_MASK = 32'((64'd1 << ADDR_LSB) - 64'd1);

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_idx_q, clr_idx_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [AW-1:0]         fetch_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  in_run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wptr_q    <= wptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wptr_d    = wptr_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_addr   = clr_idx_q;
    wr_data   = DATA_WIDTH'(NOP_WORD);

    case (state_q)
      CLEAR: begin
        wr_en     = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = LOAD;
          clr_idx_d = '0;
        end
      end
      LOAD: begin
        if (prog_valid) begin
          wr_en   = 1'b1;
          wr_addr = wptr_q;
          wr_data = prog_data;
          wptr_d  = wptr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          // A full array ends the image even without prog_last.
          if (prog_last || (wptr_q == LAST_IDX)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (reload) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          wptr_d    = '0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    if (reset) begin
      wr_en = 1'b0;
    end
  end

  imem_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_storage (
    .clk        (clk),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_addr_i  (fetch_idx),
    .rd_data_o  (rd_data)
  );

  // Outputs are forced idle while reset is held, even before the state register has been cleared.
  assign in_run       = (state_q == RUN) && !reset;
  assign fetch_idx    = Address[ADDR_LSB +: AW];
  assign misaligned   = (Address & LSB_MASK) != 32'd0;
  assign out_of_range = (Address >> (ADDR_LSB + AW)) != 32'd0;

  assign addr_fault   = in_run && (misaligned || out_of_range);
  assign Instruction  = (in_run && !misaligned && !out_of_range) ? rd_data : '0;
  assign prog_ready   = (state_q == LOAD) && !reset;
  assign ready        = in_run;
  assign load_count   = cnt_q;

endmodule

// File: tb/tb_imem_bootloader.sv
// Self-checking bench for imem_bootloader at DEPTH=32: constant fetch table plus random loads/fetches against a word-array model.
module tb_imem_bootloader;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int LSB   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   Address;
  logic [DW-1:0] Instruction;
  logic          addr_fault;
  logic          prog_valid;
  logic [DW-1:0] prog_data;
  logic          prog_last;
  logic          prog_ready;
  logic          reload;
  logic          ready;
  logic [CW-1:0] load_count;

  always #5 clk = ~clk;

  imem_bootloader #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDR_LSB   (LSB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Address     (Address),
    .Instruction (Instruction),
    .addr_fault  (addr_fault),
    .prog_valid  (prog_valid),
    .prog_data   (prog_data),
    .prog_last   (prog_last),
    .prog_ready  (prog_ready),
    .reload      (reload),
    .ready       (ready),
    .load_count  (load_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the words the core should see, how many were accepted, whether fetches are live.
  logic [DW-1:0] mem_m [DEPTH];
  int            count_m;
  bit            run_m;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    count_m = 0;
    run_m   = 1'b0;
  endtask

  task automatic check_fetch(input logic [31:0] a);
    logic        exp_fault;
    logic [31:0] exp_instr;
    Address = a;
    #1;
    exp_fault = run_m && (((a % 4) != 0) || (a >= 32'(DEPTH * 4)));
    exp_instr = '0;
    if (run_m && !exp_fault) exp_instr = mem_m[int'(a / 4)];
    check($sformatf("fault@%08h", a), 32'(addr_fault), 32'(exp_fault));
    check($sformatf("instr@%08h", a), Instruction, exp_instr);
  endtask

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    prog_valid = 1'b1;
    prog_data  = d;
    prog_last  = last;
    step();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    prog_data  = $urandom;
    mem_m[count_m] = d;
    count_m++;
    if (last || count_m == DEPTH) run_m = 1'b1;
  endtask

  // Counts cycles until prog_ready, checking that ready never rises meanwhile; -1 on timeout.
  task automatic wait_prog_ready(output int n);
    bit ready_seen = 1'b0;
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (ready) ready_seen = 1'b1;
      if (prog_ready) begin
        n = i;
        break;
      end
    end
    check("ready_low_during_clear", 32'(ready_seen), 32'd0);
  endtask

  task automatic do_reload();
    step();
    reload = 1'b1;
    step();
    reload = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [DW-1:0] w;

    tbl[0] = '{32'h0000_0008, 32'h0C00_0004, 1'b0};
    tbl[1] = '{32'h0000_0000, 32'h2004_0005, 1'b0};
    tbl[2] = '{32'h0000_0004, 32'h0000_1026, 1'b0};
    tbl[3] = '{32'h0000_0050, 32'h0000_0000, 1'b0};
    tbl[4] = '{32'h0000_0006, 32'h0000_0000, 1'b1};
    tbl[5] = '{32'h0000_0080, 32'h0000_0000, 1'b1};
    tbl[6] = '{32'h0000_007C, 32'h0000_0000, 1'b0};
    tbl[7] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b1};

    reset      = 1'b1;
    Address    = 32'h0000_0006;
    prog_valid = 1'b0;
    prog_data  = '0;
    prog_last  = 1'b0;
    reload     = 1'b0;
    model_clear();

    repeat (3) step();
    check("rst_prog_ready", 32'(prog_ready), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_fault", 32'(addr_fault), 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_load_count", 32'(load_count), 32'd0);

    // Power-on clear, then a 19-word image terminated by prog_last.
    reset = 1'b0;
    wait_prog_ready(n);
    check("clear_cycles_after_reset", n, 32'd32);
    for (int i = 0; i < 19; i++) begin
      if (i == 0)      w = 32'h2004_0005;
      else if (i == 1) w = 32'h0000_1026;
      else if (i == 2) w = 32'h0C00_0004;
      else             w = $urandom;
      if (i == 18) check("ready_before_last", 32'(ready), 32'd0);
      load_word(w, i == 18);
    end
    check("ready_after_last", 32'(ready), 32'd1);
    check("prog_ready_in_run", 32'(prog_ready), 32'd0);
    check("load_count_19", 32'(load_count), 32'd19);

    for (int i = 0; i < 8; i++) begin
      Address = tbl[i].addr;
      #1;
      check($sformatf("tbl%0d_instr", i), Instruction, tbl[i].instr);
      check($sformatf("tbl%0d_fault", i), 32'(addr_fault), 32'(tbl[i].fault));
    end

    for (int i = 0; i < 24; i++) begin
      check_fetch(32'($urandom_range(0, 47) * 4) +
                  (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0));
    end

    // reload from RUN: ready drops, clear replays, prior image is gone.
    do_reload();
    check("reload_ready_drop", 32'(ready), 32'd0);
    check("reload_count_zero", 32'(load_count), 32'd0);
    wait_prog_ready(n);
    check("clear_cycles_after_reload", n, 32'd32);
    reload = 1'b1;
    step();
    reload = 1'b0;
    check("reload_in_load_ignored", 32'(prog_ready), 32'd1);
    check("reload_in_load_count", 32'(load_count), 32'd0);
    load_word(32'h1234_5678, 1'b1);
    check("one_word_ready", 32'(ready), 32'd1);
    check("one_word_count", 32'(load_count), 32'd1);
    check_fetch(32'h0000_0000);
    check_fetch(32'h0000_0004);
    check_fetch(32'h0000_0008);

    // Full 32-word image with prog_valid idling every other cycle.
    do_reload();
    wait_prog_ready(n);
    check("clear_cycles_full", n, 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 2 == 1) begin
        prog_data = $urandom;
        step();
      end
      check($sformatf("count_before_w%0d", i), 32'(load_count), i);
      load_word($urandom, 1'b0);
    end
    check("full_ready", 32'(ready), 32'd1);
    check("full_count", 32'(load_count), 32'd32);
    prog_valid = 1'b1;
    prog_data  = ~mem_m[0];
    prog_last  = 1'b1;
    step();
    prog_valid = 1'b0;
    prog_last  = 1'b0;
    check("valid_in_run_count", 32'(load_count), 32'd32);
    for (int i = 0; i < DEPTH; i++) check_fetch(32'(i * 4));
    check_fetch(32'h0000_007C);
    check_fetch(32'h0000_0080);
    check_fetch(32'h0000_0006);

    // Reset after 5 accepted words restarts from a fresh clear.
    do_reload();
    wait_prog_ready(n);
    check("clear_cycles_pre_reset", n, 32'd32);
    for (int i = 0; i < 5; i++) load_word($urandom | 32'h1, 1'b0);
    check("partial_count", 32'(load_count), 32'd5);
    reset = 1'b1;
    #1;
    check("midload_rst_prog_ready", 32'(prog_ready), 32'd0);
    check("midload_rst_ready", 32'(ready), 32'd0);
    step();
    reset = 1'b0;
    model_clear();
    check("post_rst_count", 32'(load_count), 32'd0);
    check("post_rst_ready", 32'(ready), 32'd0);
    wait_prog_ready(n);
    check("clear_cycles_post_reset", n, 32'd32);
    load_word(32'hA5A5_0001, 1'b1);
    check("post_rst_one_word_count", 32'(load_count), 32'd1);
    check_fetch(32'h0000_0000);
    check_fetch(32'h0000_0008);
    check_fetch(32'h0000_0010);

    // reset and reload together in RUN: reset gates outputs immediately, then a normal clear.
    step();
    reset   = 1'b1;
    reload  = 1'b1;
    Address = 32'h0000_0006;
    #1;
    check("rst_reload_fault", 32'(addr_fault), 32'd0);
    check("rst_reload_ready", 32'(ready), 32'd0);
    Address = 32'h0000_0000;
    #1;
    check("rst_reload_instr", Instruction, 32'd0);
    step();
    reset  = 1'b0;
    reload = 1'b0;
    model_clear();
    wait_prog_ready(n);
    check("clear_cycles_rst_reload", n, 32'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
